// File: rtl/pool2_win_sched.sv
`default_nettype none
// ============================================================================
// pool2_mul_4ns_7ns_10_1_1 / pool2_win_sched
// Pool2 window address scheduler: walks every pooling window of one plane
// and streams flat input addresses (row*in_w + col) over valid/ready.
// Revision: 1.0
// ============================================================================

module pool2_mul_4ns_7ns_10_1_1 (
    input  logic [3:0] i_a,
    input  logic [6:0] i_b,
    output logic [9:0] o_p
);
    assign o_p = {6'd0, i_a} * {3'd0, i_b};
endmodule

module pool2_win_sched #(
    parameter int ADDR_W = 10
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              ap_err,
    input  logic [3:0]        cfg_in_h,
    input  logic [6:0]        cfg_in_w,
    input  logic [1:0]        cfg_k,
    input  logic [1:0]        cfg_s,
    output logic [ADDR_W-1:0] addr_data,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              addr_last_win,
    output logic              addr_last
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_in_h;
    logic [6:0]        r_in_w;
    logic [1:0]        r_k;
    logic [1:0]        r_s;
    logic [3:0]        r_rb;
    logic [6:0]        r_cb;
    logic [1:0]        r_ky;
    logic [1:0]        r_kx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic              w_cfg_bad;
    logic              w_hs;
    logic              w_kx_end;
    logic              w_ky_end;
    logic              w_col_more;
    logic              w_row_more;
    logic              w_win_end;
    logic              w_run_end;
    logic [3:0]        w_rb_n;
    logic [6:0]        w_cb_n;
    logic [1:0]        w_ky_n;
    logic [1:0]        w_kx_n;
    logic [3:0]        w_row_n;
    logic [6:0]        w_col_n;
    logic [ADDR_W-1:0] w_prod;
    logic [ADDR_W-1:0] w_addr_n;

    assign w_cfg_bad = (cfg_k == 2'd0) || (cfg_s == 2'd0) ||
                       ({2'd0, cfg_k} > cfg_in_h) || ({5'd0, cfg_k} > cfg_in_w);

    assign addr_valid = (r_state == S_RUN);
    assign w_hs       = addr_valid & addr_ready;

    // Window-existence tests are done 8 bits wide so base+s+k never wraps.
    assign w_kx_end   = (r_kx == r_k - 2'd1);
    assign w_ky_end   = (r_ky == r_k - 2'd1);
    assign w_col_more = ({1'b0, r_cb} + {6'd0, r_s} + {6'd0, r_k}) <= {1'b0, r_in_w};
    assign w_row_more = ({4'd0, r_rb} + {6'd0, r_s} + {6'd0, r_k}) <= {4'd0, r_in_h};
    assign w_win_end  = w_kx_end & w_ky_end;
    assign w_run_end  = w_win_end & ~w_col_more & ~w_row_more;

    assign addr_last_win = addr_valid & w_win_end;
    assign addr_last     = addr_valid & w_run_end;
    assign addr_data     = r_addr;
    assign ap_err        = r_err;

    always_comb begin
        w_rb_n = r_rb;
        w_cb_n = r_cb;
        w_ky_n = r_ky;
        w_kx_n = r_kx;
        if (!w_kx_end) begin
            w_kx_n = r_kx + 2'd1;
        end else begin
            w_kx_n = 2'd0;
            if (!w_ky_end) begin
                w_ky_n = r_ky + 2'd1;
            end else begin
                w_ky_n = 2'd0;
                if (w_col_more) begin
                    w_cb_n = r_cb + {5'd0, r_s};
                end else begin
                    w_cb_n = 7'd0;
                    w_rb_n = r_rb + {2'd0, r_s};
                end
            end
        end
    end

    assign w_row_n = w_rb_n + {2'd0, w_ky_n};
    assign w_col_n = w_cb_n + {5'd0, w_kx_n};

    pool2_mul_4ns_7ns_10_1_1 u_mul (
        .i_a (w_row_n),
        .i_b (r_in_w),
        .o_p (w_prod)
    );

    assign w_addr_n = w_prod + {{(ADDR_W-7){1'b0}}, w_col_n};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_state_nxt = w_cfg_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_hs && w_run_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_in_h <= 4'd0;
            r_in_w <= 7'd0;
            r_k    <= 2'd0;
            r_s    <= 2'd0;
            r_rb   <= 4'd0;
            r_cb   <= 7'd0;
            r_ky   <= 2'd0;
            r_kx   <= 2'd0;
            r_addr <= '0;
            r_err  <= 1'b0;
        end else if (r_state == S_IDLE && ap_start) begin
            r_in_h <= cfg_in_h;
            r_in_w <= cfg_in_w;
            r_k    <= cfg_k;
            r_s    <= cfg_s;
            r_rb   <= 4'd0;
            r_cb   <= 7'd0;
            r_ky   <= 2'd0;
            r_kx   <= 2'd0;
            r_addr <= '0;
            r_err  <= w_cfg_bad;
        end else if (w_hs) begin
            r_rb   <= w_rb_n;
            r_cb   <= w_cb_n;
            r_ky   <= w_ky_n;
            r_kx   <= w_kx_n;
            r_addr <= w_addr_n;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_pool2_win_sched.sv
`default_nettype none
// ============================================================================
// tb_pool2_win_sched
// Scoreboard bench: expected address stream queued per run, popped on handshake.
// Revision: 1.0
// ============================================================================
module tb_pool2_win_sched;
    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       ap_start = 1'b0;
    logic       ap_idle, ap_done, ap_err;
    logic [3:0] cfg_in_h = 4'd0;
    logic [6:0] cfg_in_w = 7'd0;
    logic [1:0] cfg_k = 2'd0;
    logic [1:0] cfg_s = 2'd0;
    logic [9:0] addr_data;
    logic       addr_valid, addr_ready, addr_last_win, addr_last;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] q[$];

    pool2_win_sched #(.ADDR_W(10)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_err(ap_err),
        .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_k(cfg_k), .cfg_s(cfg_s),
        .addr_data(addr_data), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .addr_last_win(addr_last_win), .addr_last(addr_last)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference walk of all windows; returns the number of addresses pushed.
    task automatic push_expected(input int h, input int w, input int k, input int s,
                                 output int cnt);
        int oh, ow, row, col, a;
        logic lw, l;
        oh = (h - k) / s + 1;
        ow = (w - k) / s + 1;
        cnt = 0;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        row = oy * s + ky;
                        col = ox * s + kx;
                        a   = (row * w + col) % 1024;
                        lw  = (ky == k - 1) && (kx == k - 1);
                        l   = lw && (oy == oh - 1) && (ox == ow - 1);
                        q.push_back({l, lw, a[9:0]});
                        cnt++;
                    end
    endtask

    task automatic run_case(input int h, input int w, input int k, input int s,
                            input bit bp, input int rst_after);
        int exp_cnt, npop;
        bit fin, exp_done, held_v;
        logic [11:0] held, e;
        cfg_in_h = 4'(h); cfg_in_w = 7'(w); cfg_k = 2'(k); cfg_s = 2'(s);
        push_expected(h, w, k, s, exp_cnt);
        chk("formula_cnt", exp_cnt, ((h - k) / s + 1) * ((w - k) / s + 1) * k * k);
        npop = 0; fin = 0; exp_done = 0; held_v = 0; held = '0;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            addr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge ap_clk);
            if (c == 0) begin
                chk("start_valid", addr_valid, 1);
                chk("err_clear", ap_err, 0);
            end
            if (exp_done) begin
                chk("done_pulse", ap_done, 1);
                chk("valid_drop", addr_valid, 0);
                fin = 1;
            end else if (addr_valid) begin
                if (held_v) chk("bp_stable", {addr_last, addr_last_win, addr_data}, held);
                if (addr_ready) begin
                    held_v = 0;
                    if (q.size() == 0) begin
                        chk("extra_addr", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("addr", addr_data, e[9:0]);
                        chk("last_win", addr_last_win, e[10]);
                        chk("last", addr_last, e[11]);
                        if (h == 15 && npop == 1143) chk("wrap_1143", addr_data, 119);
                        if (e[11]) exp_done = 1;
                    end
                    npop++;
                    if (npop == rst_after) begin
                        ap_rst_n = 1'b0;
                        #1;
                        chk("rst_valid", addr_valid, 0);
                        chk("rst_data", addr_data, 0);
                        chk("rst_idle", ap_idle, 1);
                        chk("rst_flags", {ap_done, ap_err, addr_last_win, addr_last}, 0);
                        q.delete();
                        #1 ap_rst_n = 1'b1;
                        @(posedge ap_clk); #1;
                        return;
                    end
                end else begin
                    held = {addr_last, addr_last_win, addr_data};
                    held_v = 1;
                end
            end else begin
                chk("valid_gap", addr_valid, 1);
            end
            @(posedge ap_clk); #1;
        end
        if (!fin) chk("timeout", 0, 1);
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        chk("done_one_cycle", ap_done, 0);
        chk("idle_back", ap_idle, 1);
        chk("err_after", ap_err, 0);
        chk("count", npop, exp_cnt);
        chk("leftover", q.size(), 0);
        @(posedge ap_clk); #1;
    endtask

    initial begin
        addr_ready = 1'b1;
        #1;
        chk("reset_idle", ap_idle, 1);
        chk("reset_outs", {ap_done, ap_err, addr_valid, addr_last_win, addr_last}, 0);
        chk("reset_data", addr_data, 0);
        #11 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        run_case(4, 4, 2, 2, 0, -1);
        run_case(4, 4, 2, 2, 1, -1);
        run_case(4, 5, 3, 1, 0, -1);
        run_case(15, 127, 1, 1, 0, -1);

        // Illegal configuration: k larger than plane height.
        cfg_in_h = 4'd2; cfg_in_w = 7'd4; cfg_k = 2'd3; cfg_s = 2'd1;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        @(negedge ap_clk);
        chk("bad_done", ap_done, 1);
        chk("bad_err", ap_err, 1);
        chk("bad_valid", addr_valid, 0);
        @(negedge ap_clk);
        chk("bad_idle", ap_idle, 1);
        chk("bad_err_hold", ap_err, 1);
        chk("bad_valid2", addr_valid, 0);
        @(posedge ap_clk); #1;
        run_case(4, 4, 2, 2, 0, -1);

        run_case(4, 4, 2, 2, 0, 5);
        @(negedge ap_clk);
        chk("post_rst_idle", ap_idle, 1);
        chk("post_rst_valid", addr_valid, 0);
        @(posedge ap_clk); #1;
        run_case(4, 4, 2, 2, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
